// File: rtl/axi_bridge.sv
// axi_bridge: cache-arbiter level-held read/write requests -> AXI4 master
// AR/R/AW/W/B channels. One read and one write in flight at once, at most one
// outstanding per direction. Per-beat read data and write acknowledges go
// back to the arbiter.
// Optional feature macro: AXI_BRIDGE_RAW_ORDER_EN -- holds a read to the same
// 16-byte line as an in-flight write until that write has been acknowledged.
module axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  // arbiter read side
  input  logic        ren_i,
  input  logic [31:0] raddr_i,
  input  logic [7:0]  rlen_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  // arbiter write side
  input  logic        wen_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wsel_i,
  input  logic [7:0]  wlen_i,
  output logic        wdata_resp_o,
  // AR
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  // R
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  // AW
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  // W
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  // B
  input  logic [3:0]  m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

  r_state_t    r_state;
  w_state_t    w_state;
  logic [7:0]  beat;
  logic [3:0]  wsel_q;
  logic        rd_hs, wr_hs, b_hs, w_last, raw_block;

  // IDs and responses are not interpreted: single ID, errors passed through
  logic unused_ok;
  assign unused_ok = ^{m_rid, m_rresp, m_bid, m_bresp};

  assign m_arid    = AXI_ID;
  assign m_awid    = AXI_ID;
  assign m_arsize  = 3'b010;
  assign m_awsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_awburst = 2'b01;

  assign rd_hs         = m_rready & m_rvalid;
  assign rdata_valid_o = rd_hs;
  assign rdata_o       = rd_hs ? m_rdata : 32'd0;

  assign w_last       = (beat == m_awlen);
  assign wr_hs        = m_wvalid & m_wready;
  assign b_hs         = m_bready & m_bvalid;
  assign m_wdata      = wdata_i;
  assign m_wstrb      = wsel_q;
  assign m_wlast      = m_wvalid & w_last;
  // last W beat is acknowledged by the B response, not by the W handshake
  assign wdata_resp_o = (wr_hs & ~w_last) | b_hs;

`ifdef AXI_BRIDGE_RAW_ORDER_EN
  assign raw_block = (w_state != W_IDLE) && (raddr_i[31:4] == m_awaddr[31:4]);
`else
  assign raw_block = 1'b0;
`endif

  // read FSM: launch AR from idle, then accept R beats until rlast
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      m_araddr  <= 32'd0;
      m_arlen   <= 8'd0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ren_i && ce_i && !raw_block) begin
          m_araddr  <= raddr_i;
          m_arlen   <= rlen_i;
          m_arvalid <= 1'b1;
          r_state   <= R_AR;
        end
        R_AR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
          r_state   <= R_DATA;
        end
        R_DATA: if (m_rvalid && m_rlast) begin
          m_rready <= 1'b0;
          r_state  <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // write FSM: AW, then W beats counted against awlen, then wait for B
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      m_awaddr  <= 32'd0;
      m_awlen   <= 8'd0;
      wsel_q    <= 4'd0;
      beat      <= 8'd0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (wen_i && ce_i) begin
          m_awaddr  <= waddr_i;
          m_awlen   <= wlen_i;
          wsel_q    <= wsel_i;
          beat      <= 8'd0;
          m_awvalid <= 1'b1;
          w_state   <= W_AW;
        end
        W_AW: if (m_awready) begin
          m_awvalid <= 1'b0;
          m_wvalid  <= 1'b1;
          w_state   <= W_DATA;
        end
        W_DATA: if (m_wready) begin
          if (w_last) begin
            m_wvalid <= 1'b0;
            m_bready <= 1'b1;
            w_state  <= W_RESP;
          end else begin
            beat <= beat + 8'd1;
          end
        end
        W_RESP: if (m_bvalid) begin
          m_bready <= 1'b0;
          w_state  <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bridge.sv
// tb_axi_bridge: directed + randomized bench for axi_bridge. The bench plays
// both the cache arbiter and the AXI slave; expected beats, pulses and
// addresses come from per-transaction data queues built up front.
module tb_axi_bridge;

`ifdef AXI_BRIDGE_RAW_ORDER_EN
  localparam bit RAW_EN = 1'b1;
`else
  localparam bit RAW_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ce_i;
  logic        ren_i, wen_i;
  logic [31:0] raddr_i, waddr_i, wdata_i;
  logic [7:0]  rlen_i, wlen_i;
  logic [3:0]  wsel_i;
  logic [31:0] rdata_o;
  logic        rdata_valid_o, wdata_resp_o;
  logic [3:0]  m_arid, m_awid, m_rid, m_bid;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;

  int n_cmp = 0;
  int n_mis = 0;

  axi_bridge dut (
    .clk(clk), .rst(rst), .ce_i(ce_i),
    .ren_i(ren_i), .raddr_i(raddr_i), .rlen_i(rlen_i),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wsel_i(wsel_i),
    .wlen_i(wlen_i), .wdata_resp_o(wdata_resp_o),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  // hard stop in case a sequence ever stalls
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // arbiter read request + slave AR/R responder; base!=0 gives base+i data
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input int ar_dly, input int max_gap, input logic [31:0] base);
    logic [31:0] exp_q[$];
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back(base != 0 ? base + i : $urandom);
    @(posedge clk); #1;
    ren_i = 1'b1; raddr_i = addr; rlen_i = len;
    @(posedge clk); #1;
    chk("ar_launch_latency", m_arvalid, 1);
    chk("araddr", m_araddr, addr);
    chk("arlen", m_arlen, {24'd0, len});
    chk("arid", m_arid, 0);
    chk("arsize_arburst", {m_arsize, m_arburst}, {3'b010, 2'b01});
    for (int i = 0; i < ar_dly; i++) begin
      chk("ar_hold", m_arvalid, 1);
      @(posedge clk); #1;
    end
    m_arready = 1'b1; #1;
    chk("ar_hs_valid", m_arvalid, 1);
    @(posedge clk); #1;
    m_arready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      int gap;
      gap = $urandom_range(max_gap, 0);
      for (int g = 0; g < gap; g++) begin
        #1;
        chk("r_gap_no_pulse", rdata_valid_o, 0);
        chk("r_gap_rready", m_rready, 1);
        @(posedge clk); #1;
      end
      m_rvalid = 1'b1; m_rdata = exp_q[b]; m_rlast = (b == int'(len));
      m_rresp = 2'($urandom_range(3, 0)); #1;
      chk("r_beat_pulse", rdata_valid_o, 1);
      chk("r_beat_data", rdata_o, exp_q[b]);
      @(posedge clk); #1;
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = $urandom;
    end
    ren_i = 1'b0; #1;
    chk("r_idle_rready", m_rready, 0);
    chk("r_idle_no_pulse", rdata_valid_o, 0);
    @(posedge clk); #1;
    chk("r_no_relaunch", m_arvalid, 0);
  endtask

  // arbiter write request + slave AW/W/B responder
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] sel,
                          input int aw_dly, input int b_dly, input int max_gap);
    logic [31:0] d[$];
    int pulses, b;
    pulses = 0; b = 0;
    for (int i = 0; i <= int'(len); i++) d.push_back($urandom);
    @(posedge clk); #1;
    wen_i = 1'b1; waddr_i = addr; wlen_i = len; wsel_i = sel; wdata_i = d[0];
    @(posedge clk); #1;
    chk("aw_launch_latency", m_awvalid, 1);
    chk("awaddr", m_awaddr, addr);
    chk("awlen", m_awlen, {24'd0, len});
    chk("awid", m_awid, 0);
    chk("awsize_awburst", {m_awsize, m_awburst}, {3'b010, 2'b01});
    for (int i = 0; i < aw_dly; i++) begin
      chk("aw_hold", m_awvalid, 1);
      chk("aw_no_wvalid", m_wvalid, 0);
      @(posedge clk); #1;
    end
    m_awready = 1'b1; #1;
    chk("aw_hs_valid", m_awvalid, 1);
    @(posedge clk); #1;
    m_awready = 1'b0;
    while (b <= int'(len)) begin
      int gap;
      gap = $urandom_range(max_gap, 0);
      for (int g = 0; g < gap; g++) begin
        #1;
        chk("w_gap_wvalid", m_wvalid, 1);
        chk("w_gap_no_resp", wdata_resp_o, 0);
        @(posedge clk); #1;
      end
      m_wready = 1'b1; #1;
      chk("w_beat_wvalid", m_wvalid, 1);
      chk("w_beat_data", m_wdata, d[b]);
      chk("w_beat_strb", m_wstrb, sel);
      chk("w_beat_last", m_wlast, (b == int'(len)));
      chk("w_beat_resp", wdata_resp_o, (b != int'(len)));
      pulses += int'(wdata_resp_o);
      @(posedge clk); #1;
      m_wready = 1'b0;
      b++;
      if (b <= int'(len)) wdata_i = d[b];
    end
    for (int i = 0; i < b_dly; i++) begin
      #1;
      chk("b_wait_bready", m_bready, 1);
      chk("b_wait_wvalid", m_wvalid, 0);
      chk("b_wait_no_resp", wdata_resp_o, 0);
      pulses += int'(wdata_resp_o);
      @(posedge clk); #1;
    end
    m_bvalid = 1'b1; m_bresp = 2'($urandom_range(3, 0)); #1;
    chk("b_resp_pulse", wdata_resp_o, 1);
    pulses += int'(wdata_resp_o);
    @(posedge clk); #1;
    m_bvalid = 1'b0; wen_i = 1'b0; #1;
    chk("w_idle_bready", m_bready, 0);
    chk("w_pulse_count", pulses, int'(len) + 1);
    @(posedge clk); #1;
    chk("w_no_relaunch", m_awvalid, 0);
  endtask

  initial begin
    rst = 1'b1; ce_i = 1'b1;
    ren_i = 0; raddr_i = 0; rlen_i = 0;
    wen_i = 0; waddr_i = 0; wdata_i = 0; wsel_i = 0; wlen_i = 0;
    m_arready = 0; m_rid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
    m_awready = 0; m_wready = 0; m_bid = 0; m_bresp = 0; m_bvalid = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
    chk("rst_pulses", {rdata_valid_o, wdata_resp_o}, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_lens", {m_arlen, m_awlen}, 0);
    chk("rst_wstrb_wlast", {m_wstrb, m_wlast}, 0);
    rst = 1'b0;

    // directed plan items
    do_read(32'h1C00_0014, 8'd3, 0, 0, 32'hA0);
    do_read($urandom, 8'd0, 5, 0, 32'd0);
    do_write($urandom, 8'd3, 4'hF, 0, 3, 0);
    do_write($urandom, 8'd0, 4'b0011, 2, 1, 0);

    // ce_i low blocks new launches
    @(posedge clk); #1;
    ce_i = 1'b0; ren_i = 1'b1; wen_i = 1'b1; raddr_i = $urandom; waddr_i = $urandom;
    repeat (3) begin
      @(posedge clk); #1;
      chk("ce_block_ar", m_arvalid, 0);
      chk("ce_block_aw", m_awvalid, 0);
    end
    ren_i = 1'b0; wen_i = 1'b0; ce_i = 1'b1;

    // simultaneous launch, then randomized concurrent pairs
    fork
      do_read($urandom, 8'd3, 1, 2, 32'd0);
      do_write($urandom, 8'd3, 4'($urandom), 1, 2, 2);
    join
    for (int it = 0; it < 6; it++) begin
      logic [7:0] rl, wl;
      rl = ($urandom_range(1, 0) != 0) ? 8'd3 : 8'd0;
      wl = 8'($urandom_range(7, 0));
      fork
        do_read($urandom, rl, $urandom_range(3, 0), 2, 32'd0);
        do_write($urandom, wl, 4'($urandom), $urandom_range(3, 0), $urandom_range(3, 0), 2);
      join
    end

    // read to same line as a write waiting for B
    @(posedge clk); #1;
    wen_i = 1'b1; waddr_i = 32'h8000_0040; wlen_i = 8'd0; wsel_i = 4'hF; wdata_i = $urandom;
    m_awready = 1'b1;
    @(posedge clk); #1;
    chk("raw_aw", m_awvalid, 1);
    @(posedge clk); #1;
    m_awready = 1'b0; m_wready = 1'b1; #1;
    chk("raw_wlast", m_wlast, 1);
    chk("raw_no_w_pulse", wdata_resp_o, 0);
    @(posedge clk); #1;
    m_wready = 1'b0;
    chk("raw_bready", m_bready, 1);
    ren_i = 1'b1; raddr_i = 32'h8000_0048; rlen_i = 8'd0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("raw_hold", m_arvalid, !RAW_EN);
    end
    m_bvalid = 1'b1; #1;
    chk("raw_b_pulse", wdata_resp_o, 1);
    @(posedge clk); #1;
    m_bvalid = 1'b0; wen_i = 1'b0; #1;
    chk("raw_after_b", m_arvalid, !RAW_EN);
    @(posedge clk); #1;
    chk("raw_release", m_arvalid, 1);
    chk("raw_araddr", m_araddr, 32'h8000_0048);
    m_arready = 1'b1;
    @(posedge clk); #1;
    m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h5A5A_0001; #1;
    chk("raw_rdata", rdata_o, 32'h5A5A_0001);
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0; ren_i = 1'b0;

    // reset mid-transaction drops all valids
    @(posedge clk); #1;
    ren_i = 1'b1; wen_i = 1'b1; raddr_i = $urandom; waddr_i = $urandom; rlen_i = 3; wlen_i = 3;
    @(posedge clk); #1;
    chk("mid_ar", m_arvalid, 1);
    m_awready = 1'b1;
    @(posedge clk); #1;
    m_awready = 1'b0;
    chk("mid_wvalid", m_wvalid, 1);
    rst = 1'b1; ren_i = 1'b0; wen_i = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
    rst = 1'b0;

    // recovery after reset
    do_read($urandom, 8'd3, 2, 1, 32'd0);
    do_write($urandom, 8'd1, 4'b1100, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/axi_bridge.md
# axi_bridge

Converts the cache arbiter's simple level-held read/write request interface into AXI4 master channels (AR/R/AW/W/B) for the SoC interconnect. Sits directly downstream of the I/D-cache arbiter and directly upstream of the AXI crossbar. Runs one read and one write transaction concurrently, at most one outstanding per direction. Returns per-beat read data and per-beat write acknowledges to the arbiter.

## Interface
- AXI_ID, 4'd0, constant arid/awid value
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ce_i  in  1  bridge enable; 0 blocks new AR/AW issue
- ren_i  in  1  read request, held high until final beat returned
- raddr_i  in  32  read address, stable while ren_i
- rlen_i  in  8  read burst length minus one (0 or 3)
- rdata_o  out  32  read beat data
- rdata_valid_o  out  1  one-cycle pulse per accepted R beat
- wen_i  in  1  write request, held high until final wdata_resp_o
- waddr_i  in  32  write address
- wdata_i  in  32  current write beat data; arbiter advances it on each wdata_resp_o
- wsel_i  in  4  byte strobes, constant for the burst
- wlen_i  in  8  write burst length minus one
- wdata_resp_o  out  1  one-cycle pulse per completed write beat
- m_arid/araddr/arlen  out  4/32/8  AR fields; arsize=3'b010, arburst=2'b01 constant
- m_arvalid  out 1 / m_arready  in 1  AR handshake
- m_rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  R channel; m_rready out 1
- m_awid/awaddr/awlen  out  4/32/8  AW fields; awsize=3'b010, awburst=2'b01 constant
- m_awvalid  out 1 / m_awready  in 1  AW handshake
- m_wdata/wstrb/wlast/wvalid  out  32/4/1/1  W channel; m_wready in 1
- m_bid/bresp/bvalid  in  4/2/1  B channel; m_bready out 1

## Operation
- Read FSM: R_IDLE, R_AR, R_DATA.
  - R_IDLE: ren_i & ce_i -> latch raddr_i/rlen_i into araddr/arlen regs, go R_AR.
  - R_AR: m_arvalid=1; on m_arready -> R_DATA.
  - R_DATA: m_rready=1; each m_rvalid -> rdata_o=m_rdata, rdata_valid_o=1 (combinational, same cycle). m_rvalid & m_rlast -> R_IDLE.
- Write FSM: W_IDLE, W_AW, W_DATA, W_RESP.
  - W_IDLE: wen_i & ce_i -> latch waddr/wlen/wsel, clear beat counter, go W_AW.
  - W_AW: m_awvalid=1; on m_awready -> W_DATA.
  - W_DATA: m_wvalid=1, m_wdata=wdata_i, m_wstrb=latched wsel, m_wlast=(beat==wlen). Handshake on non-last beat -> wdata_resp_o=1, beat+1. Handshake on last beat -> W_RESP, no pulse.
  - W_RESP: m_bready=1; on m_bvalid -> wdata_resp_o=1, W_IDLE. Final pulse is therefore the B response: arbiter sees exactly wlen+1 pulses and completes only after bresp.
- Beat counter 8 bits; rresp/bresp non-OKAY ignored (data passed through).
- Read and write FSMs independent; simultaneous ren_i/wen_i both launch the same cycle.
- After returning to IDLE, request seen on next cycle is treated as new; arbiter deasserts ren_i/wen_i the cycle after final pulse, so relaunch cannot occur.

## Timing
- Reset: all FSMs IDLE; m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, rdata_valid_o, wdata_resp_o = 0; rdata_o, address/len regs, beat counter = 0.
- ren_i seen cycle N -> m_arvalid high cycle N+1.
- R beat to rdata_valid_o: 0 cycles.
- wdata_resp_o pulse at edge E -> arbiter presents next wdata_i cycle E+1; m_wvalid stays high, no bubble required.
- Reset mid-transaction: all valids drop next cycle; in-flight AXI transfer abandoned (system reset assumed global).
- ce_i=0 only gates launch from IDLE; in-progress transactions finish.

## Configuration
- AXI_BRIDGE_RAW_ORDER_EN defined: in R_IDLE, a read whose raddr_i[31:4] equals latched write address [31:4] while write FSM not in W_IDLE is held in R_IDLE until write FSM returns to W_IDLE (read-after-write ordering to same 16-byte line).
- Undefined: no address compare; read launches regardless of write state.

## Test plan
- ren_i, raddr_i=0x1C00_0014, rlen_i=3; slave returns 0xA0..0xA3, rlast on 4th -> araddr=0x1C00_0014, arlen=3, four rdata_valid_o pulses, R_IDLE after 4th.
- Uncached read rlen_i=0, arready delayed 5 cycles -> m_arvalid held 5 cycles, single pulse with rdata.
- Write wlen_i=3, wsel_i=4'hF, wready always 1, bvalid 3 cycles after wlast -> m_wlast only on beat 3, wdata_resp_o pulses after beats 0,1,2 and on bvalid (4 total).
- Write wlen_i=0, wsel_i=4'b0011, awready delayed 2 -> wstrb=4'b0011, wlast=1, single resp pulse on bvalid.
- ren_i and wen_i same cycle -> arvalid and awvalid both high next cycle, both complete independently.
- With AXI_BRIDGE_RAW_ORDER_EN: write to 0x8000_0040 in W_RESP, read 0x8000_0048 -> no arvalid until cycle after bvalid; without macro arvalid issued immediately.
